// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory boot loader:
//   word_t               32-bit instruction/address word
//   RESET_VECTOR_DEFAULT byte address of instruction word 0
//   NOP_WORD             value returned for fetches that are not served
//   HALT_ADDR            CPU halt target, never flagged as an illegal fetch
//   boot_state_e         boot FSM state encoding (LOAD -> RELEASE -> RUN)
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_WORD             = 32'h0000_0000;
    localparam word_t HALT_ADDR            = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT_LOAD    = 2'd0,
        BOOT_RELEASE = 2'd1,
        BOOT_RUN     = 2'd2
    } boot_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// ---------------------------------------------------------------------------
// instr_mem_array
// DEPTH_WORDS x 32 instruction storage with one synchronous write port and
// one combinational read port. Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable (write on rising edge)
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module instr_mem_array
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_boot.sv
// ---------------------------------------------------------------------------
// instr_mem_boot
// Boot loader + instruction memory. A word stream is loaded into storage
// while the CPU is held in reset; after the last word (or when storage is
// full) the CPU gets exactly one clock with reset still asserted, then runs
// and fetches from the loaded image.
//
// Handshake: a load word is transferred on a rising edge where load_valid
// and load_ready are both high; load_ready is high only in LOAD, and
// load_valid is ignored elsewhere.
//
// Optional feature: define INSTR_MEM_BOOT_CHECKSUM_EN to add load_checksum,
// the XOR of all accepted words (frozen once loading ends).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   load_valid/ready     load handshake; load_data word, load_last marks end
//   instr_address        CPU fetch byte address
//   instr_readdata       fetched word (combinational), NOP when not served
//   cpu_reset            CPU reset, cpu_clk_enable CPU clock enable
//   boot_done            image loaded and CPU released
//   load_checksum        (optional) XOR of accepted words
//   addr_error           sticky illegal-fetch flag
// ---------------------------------------------------------------------------
module instr_mem_boot
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 64,
    parameter word_t       RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load_valid,
    output logic  load_ready,
    input  word_t load_data,
    input  logic  load_last,
    input  word_t instr_address,
    output word_t instr_readdata,
    output logic  cpu_reset,
    output logic  cpu_clk_enable,
    output logic  boot_done,
`ifdef INSTR_MEM_BOOT_CHECKSUM_EN
    output word_t load_checksum,
`endif
    output logic  addr_error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = AW + 1;  // count must reach DEPTH_WORDS

    boot_state_e   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic  accept;
    logic  mem_we;
    word_t fetch_idx;
    logic  fetch_legal;
    word_t mem_rdata;

    assign accept = load_valid && load_ready;
    // Reset wins over a coincident handshake: nothing is written.
    assign mem_we = accept && !reset;

    // Modulo-2^32 offset from the reset vector, in words.
    assign fetch_idx   = (instr_address - RESET_VECTOR) >> 2;
    assign fetch_legal = (instr_address[1:0] == 2'b00) &&
                         (fetch_idx < 32'(count_q));

    instr_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .raddr_i (fetch_idx[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            BOOT_LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    if (load_last || (wr_ptr_q == AW'(DEPTH_WORDS - 1))) begin
                        state_d = BOOT_RELEASE;
                    end
                end
            end
            BOOT_RELEASE: state_d = BOOT_RUN;
            BOOT_RUN: begin
                if (!fetch_legal && (instr_address != HALT_ADDR)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = BOOT_LOAD;
        endcase
    end

    // Moore outputs.
    always_comb begin
        load_ready     = 1'b0;
        cpu_reset      = 1'b1;
        cpu_clk_enable = 1'b0;
        boot_done      = 1'b0;
        case (state_q)
            BOOT_LOAD:    load_ready = 1'b1;
            BOOT_RELEASE: cpu_clk_enable = 1'b1;  // one clocked reset edge
            BOOT_RUN: begin
                cpu_reset      = 1'b0;
                cpu_clk_enable = 1'b1;
                boot_done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Reads are only served in RUN, so a read never overlaps a write.
    assign instr_readdata = ((state_q == BOOT_RUN) && fetch_legal) ? mem_rdata : NOP_WORD;
    assign addr_error     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT_LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

`ifdef INSTR_MEM_BOOT_CHECKSUM_EN
    word_t checksum_q;

    // Words are only accepted in LOAD, so the value freezes after RELEASE.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ load_data;
        end
    end

    assign load_checksum = checksum_q;
`endif

endmodule

// File: doc/instr_mem_boot.md
INSTR_MEM_BOOT -- requirements
Module: instr_mem_boot

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: instruction storage depth in 32-bit words, power of two, 4..1024.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: byte address of word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  load word offered this cycle.
REQ-006 load_ready  output  1  block accepts a load word this cycle.
REQ-007 load_data  input  32  instruction word to store.
REQ-008 load_last  input  1  qualifies final word of image.
REQ-009 instr_address  input  32  CPU fetch byte address.
REQ-010 instr_readdata  output  32  fetched instruction, combinational from instr_address.
REQ-011 cpu_reset  output  1  drives CPU reset.
REQ-012 cpu_clk_enable  output  1  drives CPU clk_enable.
REQ-013 boot_done  output  1  image loaded, CPU released.
REQ-014 addr_error  output  1  sticky illegal-fetch flag.

Function
REQ-015 FSM states LOAD, RELEASE, RUN; the block SHALL enter LOAD on reset.
REQ-016 LOAD: load_ready=1, cpu_reset=1, cpu_clk_enable=0, boot_done=0.
REQ-017 Word accepted when load_valid && load_ready; written to index wr_ptr, wr_ptr then increments; wr_ptr resets to 0.
REQ-018 LOAD->RELEASE on an accepted word with load_last=1, or on the accepted word at index DEPTH_WORDS-1 regardless of load_last.
REQ-019 RELEASE lasts exactly one cycle: load_ready=0, cpu_reset=1, cpu_clk_enable=1 (CPU sees one reset edge), then ->RUN.
REQ-020 RUN: load_ready=0, cpu_reset=0, cpu_clk_enable=1, boot_done=1; load_valid ignored; FSM remains in RUN until reset.
REQ-021 loaded_count = number of accepted words; held constant in RUN.
REQ-022 Fetch index = (instr_address - RESET_VECTOR) >> 2, modulo-2^32 subtraction.
REQ-023 Fetch is legal when instr_address[1:0]==0 and index < loaded_count; instr_readdata = stored word.
REQ-024 Otherwise, and in any state other than RUN, instr_readdata = 32'h0000_0000 (NOP).
REQ-025 addr_error sets on the clock edge where state is RUN and the fetch is illegal, except instr_address==32'h0000_0000 (CPU halt target); it remains set until reset.
REQ-026 A write and a combinational read of the same index in the same cycle cannot occur (reads gated to RUN).

Reset
REQ-027 On reset=1 at a rising edge: state=LOAD, wr_ptr=0, loaded_count=0, addr_error=0; reset has priority over a simultaneous load handshake (word not written).
REQ-028 Reset mid-load or in RUN discards the image (loaded_count=0); storage contents need not be cleared.
REQ-029 Output values in reset cycle and after: load_ready=1, cpu_reset=1, cpu_clk_enable=0, boot_done=0, addr_error=0, instr_readdata=0.

Configuration
REQ-030 Macro INSTR_MEM_BOOT_CHECKSUM_EN defined: extra output load_checksum[31:0], XOR of all accepted words, cleared on reset, frozen after RELEASE.
REQ-031 Macro undefined: port load_checksum and its register are absent; all other behaviour identical.

Structure
REQ-032 Shared package mips_pkg holds the word typedef (32-bit logic), RESET_VECTOR default constant and boot FSM state enum.
REQ-033 Storage is one sub-module instr_mem_array: single synchronous write port, single combinational read port, DEPTH_WORDS x 32.

Verification
REQ-034 Load 3 words {32'h24010020, 32'h10200003, 32'h03E00008}, last on third -> RELEASE next cycle, one cycle later boot_done=1, cpu_reset=0; fetch 0,4,8 return those words.
REQ-035 After 3-word load, fetch 12 -> instr_readdata=0, addr_error=1 on next edge; fetch 0 afterwards does not clear it.
REQ-036 Load DEPTH_WORDS=64 words with load_last never set -> RELEASE after 64th acceptance; 65th load_valid sees load_ready=0.
REQ-037 Assert reset after 2 of 5 words accepted, reload 5 words -> loaded_count=5, fetch 8 returns new word 2; reset cycle coinciding with load_valid writes nothing.
REQ-038 In RUN fetch instr_address=2 -> instr_readdata=0, addr_error=1; fetch 0 alone in a fresh run -> addr_error stays 0.
REQ-039 With INSTR_MEM_BOOT_CHECKSUM_EN, load 32'hFFFF0000, 32'h00FF00FF -> load_checksum=32'hFF0000FF, unchanged by later load_valid.
